// File: rtl/hilo_divider.sv
// Iterative restoring divider for MIPS32 DIV/DIVU; one quotient bit per clock.
// quotient/remainder feed LO/HI, done is their shared write enable.
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, shf_q, dmag_q, raw_q;
    logic [CW-1:0]    cnt_q;
    logic             negq_q, negr_q, dz_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;

    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] amag_d, bmag_d, qfix_d, rfix_d;
    logic             accept_d;

    assign accept_d = (state_q == IDLE || state_q == DONE) && start && !cancel;
    assign amag_d   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign bmag_d   = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    // Borrow out of the (WIDTH+1)-bit subtract means the trial went negative.
    assign trial_d  = {acc_q, shf_q[WIDTH-1]} - {1'b0, dmag_q};

    always_comb begin
        qfix_d = negq_q ? -shf_q : shf_q;
        rfix_d = negr_q ? -acc_q : acc_q;
        // Divide by zero reports the raw dividend, so bypass sign correction.
        if (dz_q) begin
            qfix_d = '1;
            rfix_d = raw_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            shf_q       <= '0;
            dmag_q      <= '0;
            raw_q       <= '0;
            cnt_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (accept_d) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                        shf_q   <= amag_d;
                        dmag_q  <= bmag_d;
                        raw_q   <= dividend;
                        cnt_q   <= CW'(WIDTH);
                        negq_q  <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        negr_q  <= signed_op && dividend[WIDTH-1];
                        dz_q    <= (divisor == '0);
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (!trial_d[WIDTH]) begin
                            acc_q <= trial_d[WIDTH-1:0];
                            shf_q <= {shf_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_q <= {acc_q[WIDTH-2:0], shf_q[WIDTH-1]};
                            shf_q <= {shf_q[WIDTH-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state_q <= FIX;
                    end
                end
                FIX: begin
                    busy_q <= 1'b0;
                    if (cancel) begin
                        state_q <= IDLE;
                    end else begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        quotient_q  <= qfix_d;
                        remainder_q <= rfix_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed and random DIV/DIVU checks against an arithmetic reference model.
module tb_hilo_divider;
    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          signed_op = 1'b0;
    logic          cancel = 1'b0;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          busy, done;
    logic [W-1:0]  quotient, remainder;

    int nerr = 0;
    int nchk = 0;

    hilo_divider #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .signed_op(signed_op),
        .cancel(cancel), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        logic signed [W-1:0] sa, sb, sq, sr;
        logic [W-1:0] uq, ur;
        sa = a;
        sb = b;
        if (b == 0) return {32'hFFFF_FFFF, a};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
            sq = sa / sb;
            sr = sa % sb;
            return {sq, sr};
        end
        uq = a / b;
        ur = a % b;
        return {uq, ur};
    endfunction

    // Runs one op from E0; optionally injects a second start inj edges after E0.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int inj);
        logic [63:0] exp;
        int n;
        exp = ref_div(a, b, s);
        @(negedge clock);
        dividend = a; divisor = b; signed_op = s; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk({tag, ".busy_e0"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clock); #1;
            n++;
            if (n == inj) begin
                start = 1'b1; dividend = ~a; divisor = 32'd3; signed_op = ~s;
            end
            if (n == inj + 1) start = 1'b0;
            if (!done && n <= W && busy !== 1'b1) chk({tag, ".busy_run"}, 64'(busy), 64'd1);
        end
        chk({tag, ".latency"}, 64'(n), 64'(W + 1));
        chk({tag, ".busy_done"}, 64'(busy), 64'd0);
        chk({tag, ".quo"}, 64'(quotient), 64'(exp[63:32]));
        chk({tag, ".rem"}, 64'(remainder), 64'(exp[31:0]));
    endtask

    task automatic idle_check(input string tag);
        logic [W-1:0] q0, r0;
        q0 = quotient; r0 = remainder;
        @(posedge clock); #1;
        chk({tag, ".done_fall"}, 64'(done), 64'd0);
        chk({tag, ".q_hold"}, 64'(quotient), 64'(q0));
        chk({tag, ".r_hold"}, 64'(remainder), 64'(r0));
    endtask

    initial begin
        logic [W-1:0] q0, r0, a, b;
        logic s;
        int seen;
        #12;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.quo", 64'(quotient), 64'd0);
        chk("rst.rem", 64'(remainder), 64'd0);
        @(negedge clock); reset = 1'b1;

        run_op("u100_7", 32'd100, 32'd7, 1'b0, -5);
        chk("u100_7.abs_q", 64'(quotient), 64'd14);
        chk("u100_7.abs_r", 64'(remainder), 64'd2);
        idle_check("u100_7");
        run_op("s-7_2", -32'sd7, 32'd2, 1'b1, -5);
        chk("s-7_2.abs_q", 64'(quotient), 64'hFFFF_FFFD);
        chk("s-7_2.abs_r", 64'(remainder), 64'hFFFF_FFFF);
        run_op("s7_-2", 32'd7, -32'sd2, 1'b1, -5);
        chk("s7_-2.abs_q", 64'(quotient), 64'hFFFF_FFFD);
        chk("s7_-2.abs_r", 64'(remainder), 64'd1);
        run_op("uffff_2", 32'hFFFF_FFFF, 32'd2, 1'b0, -5);
        run_op("u5_0", 32'd5, 32'd0, 1'b0, -5);
        run_op("s5_0", 32'd5, 32'd0, 1'b1, -5);
        chk("s5_0.abs_q", 64'(quotient), 64'hFFFF_FFFF);
        run_op("sneg_0", -32'sd9, 32'd0, 1'b1, -5);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -5);
        chk("s_ovf.abs_q", 64'(quotient), 64'h8000_0000);
        run_op("u3_10", 32'd3, 32'd10, 1'b0, -5);
        idle_check("u3_10");

        run_op("ign2nd", 32'd1000, 32'd9, 1'b0, 5);
        idle_check("ign2nd");

        // cancel mid-run: no done pulse, outputs unchanged
        q0 = quotient; r0 = remainder;
        @(negedge clock);
        dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock); cancel = 1'b1;
        @(posedge clock); #1; cancel = 1'b0;
        chk("cancel.busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        chk("cancel.no_done", 64'(seen), 64'd0);
        chk("cancel.q_hold", 64'(quotient), 64'(q0));
        chk("cancel.r_hold", 64'(remainder), 64'(r0));
        run_op("u50_3", 32'd50, 32'd3, 1'b0, -5);

        // cancel in IDLE suppresses a simultaneous start
        @(negedge clock); start = 1'b1; cancel = 1'b1;
        @(posedge clock); #1; start = 1'b0; cancel = 1'b0;
        chk("cancel_idle.busy", 64'(busy), 64'd0);

        // asynchronous reset between edges mid-operation
        @(negedge clock);
        dividend = 32'd12345; divisor = 32'd17; signed_op = 1'b0; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (19) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.done", 64'(done), 64'd0);
        chk("arst.quo", 64'(quotient), 64'd0);
        chk("arst.rem", 64'(remainder), 64'd0);
        @(negedge clock); reset = 1'b1;
        run_op("u9_4", 32'd9, 32'd4, 1'b0, -5);

        // random, back-to-back (each start lands in the previous DONE cycle)
        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: b = $urandom_range(0, 9);
                1: b = -$urandom_range(1, 9);
                2: a = $urandom_range(0, 100);
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), a, b, s, -5);
        end
        idle_check("rnd_end");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
